// File: rtl/pkg_interrupcao.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default ISR entry address and the index-width helper.
package pkg_interrupcao;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    DESVIO = 2'd1,
    EM_ISR = 2'd2
  } estado_t;

  localparam logic [12:0] ISR_ADDR_PADRAO = 13'h0100;

  // A single request line still needs a 1-bit index.
  function automatic int largura_indice(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/codificador_prioridade.sv
// Combinational fixed-priority encoder: the lowest-index active request wins.
module codificador_prioridade
  import pkg_interrupcao::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = largura_indice(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] requisicoes,
  output logic               valido,
  output logic [IW-1:0]      indice
);

  // NOTE: every output of an always_comb gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    valido = 1'b0;
    indice = '0;
    // Scan downwards so the last match written is the lowest index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (requisicoes[i]) begin
        valido = 1'b1;
        indice = IW'(i);
      end
    end
  end

endmodule

// File: rtl/controlador_interrupcao.sv
// Interrupt controller: edge-detects requests, keeps them pending and accepts
// the highest-priority unmasked one at an instruction boundary.
module controlador_interrupcao
  import pkg_interrupcao::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    NUM_IRQ    = 4,
  parameter logic [ADDR_WIDTH-1:0] ISR_ADDR   = ISR_ADDR_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic [NUM_IRQ-1:0]    mascara,
  input  logic [ADDR_WIDTH-1:0] valor_pc,
  input  logic                  fim_instrucao,
  input  logic                  retorno_interrupcao,
  output logic                  desvio_isr,
  output logic [ADDR_WIDTH-1:0] endereco_isr,
  output logic                  em_interrupcao,
  output logic [ADDR_WIDTH-1:0] pc_interrup,
  output logic [DATA_WIDTH-1:0] qual_interrupcao,
  output logic [NUM_IRQ-1:0]    pendentes
);

  localparam int IW = largura_indice(NUM_IRQ);

  estado_t            estado, estado_prox;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] borda;
  logic [NUM_IRQ-1:0] limpa;
  logic               valido;
  logic [IW-1:0]      indice;
  logic               aceita;
  logic               retorna;

  assign endereco_isr = ISR_ADDR;
  assign borda        = irq & ~irq_d;

  codificador_prioridade #(
    .NUM_REQ (NUM_IRQ)
  ) u_prioridade (
    .requisicoes (pendentes & mascara),
    .valido      (valido),
    .indice      (indice)
  );

  assign aceita  = (estado == OCIOSO) && fim_instrucao && valido;
  assign retorna = (estado == EM_ISR) && retorno_interrupcao;

  always_comb begin
    limpa = '0;
    if (aceita) limpa[indice] = 1'b1;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (aceita) estado_prox = DESVIO;
      DESVIO:  estado_prox = EM_ISR;
      EM_ISR:  if (retorno_interrupcao) estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado           <= OCIOSO;
      irq_d            <= '0;
      pendentes        <= '0;
      pc_interrup      <= '0;
      qual_interrupcao <= '0;
      desvio_isr       <= 1'b0;
      em_interrupcao   <= 1'b0;
    end else begin
      estado         <= estado_prox;
      irq_d          <= irq;
      // A fresh edge on the source being accepted re-sets its bit.
      pendentes      <= (pendentes & ~limpa) | borda;
      desvio_isr     <= (estado_prox == DESVIO);
      em_interrupcao <= (estado_prox != OCIOSO);
      if (aceita) begin
        pc_interrup      <= valor_pc;
        qual_interrupcao <= DATA_WIDTH'(indice) + DATA_WIDTH'(1);
      end else if (retorna) begin
        qual_interrupcao <= '0;
      end
    end
  end

endmodule

// File: tb/tb_controlador_interrupcao.sv
// Self-checking bench for controlador_interrupcao: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_controlador_interrupcao;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [N-1:0]  mascara = '0;
  logic [AW-1:0] valor_pc = '0;
  logic          fim_instrucao = 1'b0;
  logic          retorno_interrupcao = 1'b0;
  logic          desvio_isr;
  logic [AW-1:0] endereco_isr;
  logic          em_interrupcao;
  logic [AW-1:0] pc_interrup;
  logic [DW-1:0] qual_interrupcao;
  logic [N-1:0]  pendentes;

  int vetores = 0;
  int erros   = 0;

  // Behavioural model: "servicing" covers the whole ISR including the branch
  // cycle; "branch" marks the single cycle right after acceptance.
  logic [N-1:0]  m_pend, m_irq_prev;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_qual;
  bit            m_servicing, m_branch;

  always #5 clock = ~clock;

  controlador_interrupcao #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_IRQ    (N),
    .ISR_ADDR   (13'h0100)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .irq                 (irq),
    .mascara             (mascara),
    .valor_pc            (valor_pc),
    .fim_instrucao       (fim_instrucao),
    .retorno_interrupcao (retorno_interrupcao),
    .desvio_isr          (desvio_isr),
    .endereco_isr        (endereco_isr),
    .em_interrupcao      (em_interrupcao),
    .pc_interrup         (pc_interrup),
    .qual_interrupcao    (qual_interrupcao),
    .pendentes           (pendentes)
  );

  task automatic modelo_reset();
    m_pend = '0; m_irq_prev = '0; m_pc = '0; m_qual = '0;
    m_servicing = 0; m_branch = 0;
  endtask

  // Drives one cycle of inputs, advances the model over the rising edge and
  // returns 1 time unit after it so outputs can be sampled.
  task automatic ciclo(input logic [N-1:0] i_irq, input logic [N-1:0] i_mask,
                       input logic [AW-1:0] i_pc, input bit i_fim, input bit i_ret);
    bit was_branch;
    logic [N-1:0] rising;
    @(negedge clock);
    irq = i_irq; mascara = i_mask; valor_pc = i_pc;
    fim_instrucao = i_fim; retorno_interrupcao = i_ret;
    @(posedge clock);
    rising     = i_irq & ~m_irq_prev;
    m_irq_prev = i_irq;
    was_branch = m_branch;
    m_branch   = 0;
    if (!m_servicing) begin
      if (i_fim) begin
        for (int i = 0; i < N; i++) begin
          if (m_pend[i] && i_mask[i] && !m_servicing) begin
            m_servicing = 1;
            m_branch    = 1;
            m_pc        = i_pc;
            m_qual      = DW'(i + 1);
            m_pend[i]   = 1'b0;
          end
        end
      end
    end else if (!was_branch && i_ret) begin
      m_servicing = 0;
      m_qual      = '0;
    end
    m_pend = m_pend | rising;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vetores++;
    if ({desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes} !== '0) begin
      erros++;
      $display("FAIL reset_outputs: got desvio=%0b em=%0b pc=%h qual=%0d pend=%b expected all zero",
               desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes);
    end
    vetores++;
    if (endereco_isr !== 13'h0100) begin
      erros++;
      $display("FAIL reset_endereco_isr: got %h expected 0100", endereco_isr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    modelo_reset();
  endtask

  task automatic test_single_irq();
    ciclo(4'b0100, 4'hF, 13'h0042, 0, 0);
    vetores++;
    if (pendentes !== 4'b0100) begin
      erros++; $display("FAIL single_pending: got %b expected 0100", pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0042, 1, 0);
    vetores++;
    if ({desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao[3:0], pendentes} !==
        {1'b1, 1'b1, 13'h0042, 4'd3, 4'b0000}) begin
      erros++;
      $display("FAIL single_accept: got desvio=%0b em=%0b pc=%h qual=%0d pend=%b expected 1 1 0042 3 0000",
               desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0050, 0, 0);
    vetores++;
    if ({desvio_isr, em_interrupcao} !== 2'b01) begin
      erros++; $display("FAIL single_desvio_one_cycle: got desvio=%0b em=%0b expected 0 1", desvio_isr, em_interrupcao);
    end
    ciclo(4'b0000, 4'hF, 13'h0051, 0, 1);
    vetores++;
    if ({em_interrupcao, qual_interrupcao, pc_interrup} !== {1'b0, 32'd0, 13'h0042}) begin
      erros++;
      $display("FAIL single_return: got em=%0b qual=%0d pc=%h expected 0 0 0042", em_interrupcao, qual_interrupcao, pc_interrup);
    end
  endtask

  task automatic test_priority();
    ciclo(4'b1010, 4'hF, 13'h0010, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0010, 1, 0);
    vetores++;
    if ({qual_interrupcao, pendentes} !== {32'd2, 4'b1000}) begin
      erros++; $display("FAIL priority_first: got qual=%0d pend=%b expected 2 1000", qual_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0011, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0012, 0, 1);
    ciclo(4'b0000, 4'hF, 13'h0020, 1, 0);
    vetores++;
    if ({desvio_isr, qual_interrupcao, pc_interrup, pendentes} !== {1'b1, 32'd4, 13'h0020, 4'b0000}) begin
      erros++;
      $display("FAIL priority_second: got desvio=%0b qual=%0d pc=%h pend=%b expected 1 4 0020 0000",
               desvio_isr, qual_interrupcao, pc_interrup, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0021, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0022, 0, 1);
  endtask

  task automatic test_masking();
    ciclo(4'b0001, 4'b1110, 13'h0030, 0, 0);
    ciclo(4'b0001, 4'b1110, 13'h0031, 1, 0);
    vetores++;
    if ({desvio_isr, em_interrupcao, pendentes} !== {1'b0, 1'b0, 4'b0001}) begin
      erros++;
      $display("FAIL mask_blocks: got desvio=%0b em=%0b pend=%b expected 0 0 0001", desvio_isr, em_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'b1111, 13'h0032, 0, 0);
    ciclo(4'b0000, 4'b1111, 13'h0033, 1, 0);
    vetores++;
    if ({desvio_isr, qual_interrupcao, pc_interrup} !== {1'b1, 32'd1, 13'h0033}) begin
      erros++;
      $display("FAIL mask_unmasked: got desvio=%0b qual=%0d pc=%h expected 1 1 0033", desvio_isr, qual_interrupcao, pc_interrup);
    end
    ciclo(4'b0000, 4'hF, 13'h0034, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0035, 0, 1);
  endtask

  task automatic test_level_hold();
    repeat (10) ciclo(4'b0010, 4'hF, 13'h0040, 0, 0);
    vetores++;
    if (pendentes !== 4'b0010) begin
      erros++; $display("FAIL level_single_event: got %b expected 0010", pendentes);
    end
    ciclo(4'b0010, 4'hF, 13'h0041, 1, 0);
    repeat (3) ciclo(4'b0010, 4'hF, 13'h0042, 0, 0);
    vetores++;
    if ({qual_interrupcao, pendentes} !== {32'd2, 4'b0000}) begin
      erros++; $display("FAIL level_no_reset: got qual=%0d pend=%b expected 2 0000", qual_interrupcao, pendentes);
    end
    ciclo(4'b0011, 4'hF, 13'h0043, 1, 0);
    ciclo(4'b0011, 4'hF, 13'h0044, 1, 0);
    vetores++;
    if ({desvio_isr, em_interrupcao, qual_interrupcao, pendentes} !== {1'b0, 1'b1, 32'd2, 4'b0001}) begin
      erros++;
      $display("FAIL no_nesting: got desvio=%0b em=%0b qual=%0d pend=%b expected 0 1 2 0001",
               desvio_isr, em_interrupcao, qual_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0045, 0, 1);
    ciclo(4'b0000, 4'hF, 13'h0046, 1, 0);
    vetores++;
    if ({desvio_isr, qual_interrupcao} !== {1'b1, 32'd1}) begin
      erros++; $display("FAIL nest_after_return: got desvio=%0b qual=%0d expected 1 1", desvio_isr, qual_interrupcao);
    end
    ciclo(4'b0000, 4'hF, 13'h0047, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0048, 0, 1);
  endtask

  task automatic test_simultaneous();
    ciclo(4'b0100, 4'hF, 13'h0060, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0061, 1, 0);
    // Branch cycle: boundary and return must both be ignored.
    ciclo(4'b1000, 4'hF, 13'h0062, 1, 1);
    vetores++;
    if ({desvio_isr, em_interrupcao, qual_interrupcao, pendentes} !== {1'b0, 1'b1, 32'd3, 4'b1000}) begin
      erros++;
      $display("FAIL desvio_ignores: got desvio=%0b em=%0b qual=%0d pend=%b expected 0 1 3 1000",
               desvio_isr, em_interrupcao, qual_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0063, 1, 1);
    vetores++;
    if ({desvio_isr, em_interrupcao, qual_interrupcao, pendentes} !== {1'b0, 1'b0, 32'd0, 4'b1000}) begin
      erros++;
      $display("FAIL ret_and_fim: got desvio=%0b em=%0b qual=%0d pend=%b expected 0 0 0 1000",
               desvio_isr, em_interrupcao, qual_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0064, 0, 0);
    vetores++;
    if (desvio_isr !== 1'b0) begin
      erros++; $display("FAIL ret_and_fim_no_branch: got %0b expected 0", desvio_isr);
    end
    ciclo(4'b0000, 4'hF, 13'h0065, 1, 0);
    vetores++;
    if ({desvio_isr, qual_interrupcao, pc_interrup} !== {1'b1, 32'd4, 13'h0065}) begin
      erros++;
      $display("FAIL ret_then_accept: got desvio=%0b qual=%0d pc=%h expected 1 4 0065", desvio_isr, qual_interrupcao, pc_interrup);
    end
    ciclo(4'b0000, 4'hF, 13'h0066, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0067, 0, 1);
  endtask

  task automatic test_set_wins();
    ciclo(4'b0001, 4'hF, 13'h0070, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0071, 0, 0);
    ciclo(4'b0001, 4'hF, 13'h0072, 1, 0);
    vetores++;
    if ({qual_interrupcao, pendentes} !== {32'd1, 4'b0001}) begin
      erros++; $display("FAIL set_wins: got qual=%0d pend=%b expected 1 0001", qual_interrupcao, pendentes);
    end
    ciclo(4'b0000, 4'hF, 13'h0073, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0074, 0, 1);
    ciclo(4'b0000, 4'hF, 13'h0075, 1, 0);
    ciclo(4'b0000, 4'hF, 13'h0076, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0077, 0, 1);
  endtask

  task automatic test_random();
    logic [N-1:0]  r_irq, r_mask;
    logic [AW-1:0] r_pc;
    bit            r_fim, r_ret;
    for (int k = 0; k < 400; k++) begin
      r_irq  = N'($urandom);
      r_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      r_pc   = AW'($urandom);
      r_fim  = ($urandom_range(0, 2) == 0);
      r_ret  = ($urandom_range(0, 4) == 0);
      ciclo(r_irq, r_mask, r_pc, r_fim, r_ret);
      vetores++;
      if ({desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes} !==
          {m_branch, m_servicing, m_pc, m_qual, m_pend}) begin
        erros++;
        $display("FAIL random_cycle_%0d: got desvio=%0b em=%0b pc=%h qual=%0d pend=%b expected %0b %0b %h %0d %b",
                 k, desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes,
                 m_branch, m_servicing, m_pc, m_qual, m_pend);
      end
    end
  endtask

  task automatic test_reset_mid_isr();
    ciclo(4'b0000, 4'hF, 13'h0080, 0, 0);
    ciclo(4'b0010, 4'hF, 13'h0081, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0082, 1, 0);
    ciclo(4'b0100, 4'hF, 13'h0083, 0, 0);
    vetores++;
    if (em_interrupcao !== 1'b1) begin
      erros++; $display("FAIL reset_mid_isr_setup: got em=%0b expected 1", em_interrupcao);
    end
    #2 reset_n = 1'b0;
    #1;
    vetores++;
    if ({desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes} !== '0) begin
      erros++;
      $display("FAIL reset_mid_isr_async: got desvio=%0b em=%0b pc=%h qual=%0d pend=%b expected all zero",
               desvio_isr, em_interrupcao, pc_interrup, qual_interrupcao, pendentes);
    end
    @(negedge clock);
    irq = '0;
    @(negedge clock);
    reset_n = 1'b1;
    modelo_reset();
    ciclo(4'b1000, 4'hF, 13'h0090, 0, 0);
    ciclo(4'b0000, 4'hF, 13'h0091, 1, 0);
    vetores++;
    if ({desvio_isr, qual_interrupcao, pc_interrup} !== {1'b1, 32'd4, 13'h0091}) begin
      erros++;
      $display("FAIL reset_back_to_idle: got desvio=%0b qual=%0d pc=%h expected 1 4 0091", desvio_isr, qual_interrupcao, pc_interrup);
    end
  endtask

  initial begin
    modelo_reset();
    test_reset();
    test_single_irq();
    test_priority();
    test_masking();
    test_level_hold();
    test_simultaneous();
    test_set_wins();
    test_random();
    test_reset_mid_isr();
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
